modulo_varredura_display_ac: RTL and testbench
==============================================

# modulo_varredura_display_ac

Parametrised multiplexed display scanner: time-multiplexes N_DIG BCD digits onto one shared 7-segment bus, driving one active column line at a time. Each digit carries a 2-bit status code selecting off, on, blinking, or on with decimal point. It replaces the fixed 2-bit-status-to-4-column decode with a clocked scan, inter-column blanking, frame-synchronous input capture and blink timing, and sits between the control logic and the display pins.

## Interface
- N_DIG, 4: number of digits/columns; legal range 1..8.
- DIV, 50000: clock cycles per column slot; must be at least BLANK+2.
- BLANK, 2: cycles at the start of each slot with all columns inactive (anti-ghosting); may be 0.
- BLINK_FRAMES, 64: full frames per blink half-period; must be at least 1.
- CLK  in  1  system clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- EN  in  1  scan enable.
- DIGITS  in  4*N_DIG  BCD digits; digit k is DIGITS[4k+3:4k].
- STAT  in  2*N_DIG  status per digit: 00 off, 01 on, 10 blink, 11 on with DP.
- AC  out  N_DIG  column enables, active-low, at most one low.
- SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  out  1  decimal point, active-low.
- FRAME_DONE  out  1  one-cycle pulse when the last column slot completes.

## Operation
- Prescaler `s` counts 0..DIV-1 while EN=1, then wraps. On the wrap, column index `k` advances, and `k` wraps from N_DIG-1 to 0.
- On reset release (first EN=1 cycle with s=0, k=0), and on every k wrap, DIGITS and STAT are captured into snapshot registers. Input changes mid-frame are not visible until the next frame.
- Column k is driven during slot cycles s in BLANK..DIV-1. During s<BLANK, AC is all 1s and SEG/DP are all 1s.
- Decode of snapshot digit k:
  - 0..9: standard patterns.
  - 10..15: dash (only g lit, SEG=7'b0111111).
- Status handling:
  - 00: segments blank, but AC still asserts, so scan timing is uniform.
  - 01: digit shown, DP off.
  - 11: digit shown, DP on.
  - 10: digit shown while blink phase=0, blank while phase=1.
- Blink phase toggles after every BLINK_FRAMES completed frames, counted at k wrap.
- EN=0 freezes s, k, the snapshot and the blink counters. AC, SEG and DP go all 1s. When EN returns to 1, the scan resumes at the same s and k.
- Reset mid-scan: all state returns to reset values immediately (asynchronous). No partial column remains asserted.

## Timing
- Reset values:
  - AC all 1s, SEG 7'h7F, DP 1, FRAME_DONE 0.
  - s=0, k=0, blink phase 0, blink frame count 0.
  - Snapshot: DIGITS 0, STAT 00.
- AC, SEG, DP and FRAME_DONE are registered: they reflect (s, k, snapshot, EN) of the previous cycle, i.e. 1-cycle latency.
- FRAME_DONE is high for exactly one cycle, the cycle after s=DIV-1 with k=N_DIG-1.
- Snapshot capture and FRAME_DONE share the same wrap edge. The new frame's column 0 is driven from the new snapshot.
- With N_DIG=1, k stays 0 and FRAME_DONE pulses every DIV cycles.
- Full frame period: N_DIG*DIV enabled cycles.
- Column duty: (DIV-BLANK)/DIV.

## Configuration
- SCAN_BLINK_EN defined: blink counter and phase are present, and status 10 blinks as specified.
- SCAN_BLINK_EN undefined: the blink logic is not built, status 10 behaves exactly as 01, and BLINK_FRAMES is ignored.

## Structure
- Shared package `display_pkg`:
  - status code constants ST_OFF, ST_ON, ST_BLINK, ST_DP;
  - segment constants SEG_BLANK, SEG_DASH;
  - the 10-entry BCD segment table.
- Sub-module `modulo_decodificador_bcd_7seg`: combinational 4-bit BCD to 7-segment active-low decoder, including the dash for 10..15. Instantiated once on the muxed snapshot digit.

## Test plan
Bench parameters: N_DIG=4, DIV=8, BLANK=2, BLINK_FRAMES=2.
- Reset then EN=1, DIGITS=16'h4321, STAT all 01 -> AC steps 1110, 1101, 1011, 0111. Each column is low for 6 cycles after 2 all-high cycles. SEG shows 1,2,3,4. FRAME_DONE pulses every 32 cycles.
- Change DIGITS to 16'h9999 mid-frame at column 1 -> columns 1..3 keep showing 2,3,4. Column 0 of the next frame shows 9.
- STAT digit 2 = 10, SCAN_BLINK_EN defined -> digit 2 visible for 2 frames, blank for 2 frames, repeating. Without the macro it is always visible.
- STAT digit 0 = 11, digit 3 = 00, DIGITS[3:0]=4'hB -> column 0 shows SEG=7'b0111111 with DP=0. Column 3 has AC low and SEG=7'h7F.
- EN=0 during column 2, s=5 for 10 cycles -> outputs all 1s within 1 cycle. After EN=1, column 2 resumes for its remaining 3 cycles.
- RST_N low during column 3 -> AC=all 1s, SEG=7'h7F and FRAME_DONE=0 immediately, with no clock edge needed. After release the scan restarts at column 0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants for the multiplexed display scanner: status codes,
// active-low segment patterns ({g,f,e,d,c,b,a}) and the BCD segment table.
package display_pkg;

  localparam logic [1:0] ST_OFF   = 2'b00;
  localparam logic [1:0] ST_ON    = 2'b01;
  localparam logic [1:0] ST_BLINK = 2'b10;
  localparam logic [1:0] ST_DP    = 2'b11;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] BCD_SEG_TABLE [10] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/modulo_decodificador_bcd_7seg.sv
// Combinational BCD to active-low 7-segment decoder; codes 10..15 show a dash.
module modulo_decodificador_bcd_7seg
  import display_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    for (int i = 0; i < 10; i++) begin
      if (bcd == 4'(i)) seg = BCD_SEG_TABLE[i];
    end
  end

endmodule

// File: rtl/modulo_varredura_display_ac.sv
// Multiplexed display scanner with inter-column blanking and frame-synchronous capture.
// Optional blink timing is built only when SCAN_BLINK_EN is defined.
module modulo_varredura_display_ac
  import display_pkg::*;
#(
  parameter int N_DIG        = 4,
  parameter int DIV          = 50000,
  parameter int BLANK        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 EN,
  input  logic [4*N_DIG-1:0]   DIGITS,
  input  logic [2*N_DIG-1:0]   STAT,
  output logic [N_DIG-1:0]     AC,
  output logic [6:0]           SEG,
  output logic                 DP,
  output logic                 FRAME_DONE
);

  localparam int SW = $clog2(DIV);
  localparam int KW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  if (N_DIG < 1 || N_DIG > 8 || BLANK < 0 || DIV < BLANK + 2 || BLINK_FRAMES < 1) begin : g_bad_param
    $error("modulo_varredura_display_ac: illegal parameter combination");
  end

  logic [SW-1:0]        s_q, s_d;
  logic [KW-1:0]        k_q, k_d;
  logic                 primed_q, primed_d;
  logic [4*N_DIG-1:0]   snap_dig_q, snap_dig_d;
  logic [2*N_DIG-1:0]   snap_st_q, snap_st_d;
  logic [N_DIG-1:0]     ac_q, ac_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;
  logic                 fd_q, fd_d;

  logic                 slot_end, frame_end, blink_off, visible;
  logic [4*N_DIG-1:0]   eff_dig;
  logic [2*N_DIG-1:0]   eff_st;
  logic [3:0]           cur_dig;
  logic [1:0]           cur_st;
  logic [6:0]           dec_seg;

  assign slot_end  = (s_q == SW'(DIV - 1));
  assign frame_end = slot_end && (k_q == KW'(N_DIG - 1));

  // The very first enabled cycle shows the live inputs, since they are being captured then.
  assign eff_dig = primed_q ? snap_dig_q : DIGITS;
  assign eff_st  = primed_q ? snap_st_q  : STAT;

  always_comb begin
    s_d        = s_q;
    k_d        = k_q;
    primed_d   = primed_q;
    snap_dig_d = snap_dig_q;
    snap_st_d  = snap_st_q;
    if (EN) begin
      primed_d = 1'b1;
      if (!primed_q || frame_end) begin
        snap_dig_d = DIGITS;
        snap_st_d  = STAT;
      end
      if (slot_end) begin
        s_d = '0;
        k_d = frame_end ? '0 : k_q + 1'b1;
      end else begin
        s_d = s_q + 1'b1;
      end
    end
  end

  always_comb begin
    cur_dig = eff_dig[3:0];
    cur_st  = eff_st[1:0];
    for (int i = 0; i < N_DIG; i++) begin
      if (k_q == KW'(i)) begin
        cur_dig = eff_dig[4*i +: 4];
        cur_st  = eff_st[2*i +: 2];
      end
    end
  end

  modulo_decodificador_bcd_7seg u_dec (
    .bcd (cur_dig),
    .seg (dec_seg)
  );

`ifdef SCAN_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;

  always_comb begin
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    if (EN && frame_end) begin
      if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
        bcnt_d  = '0;
        phase_d = ~phase_q;
      end else begin
        bcnt_d = bcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      bcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
    end
  end

  assign blink_off = phase_q;
`else
  assign blink_off = 1'b0;
`endif

  // Status OFF still pulls the column low so every slot has identical timing.
  always_comb begin
    visible = (cur_st != ST_OFF) && !((cur_st == ST_BLINK) && blink_off);
    ac_d    = '1;
    seg_d   = SEG_BLANK;
    dp_d    = 1'b1;
    fd_d    = 1'b0;
    if (EN) begin
      fd_d = frame_end;
      if (int'(s_q) >= BLANK) begin
        for (int i = 0; i < N_DIG; i++) begin
          if (k_q == KW'(i)) ac_d[i] = 1'b0;
        end
        if (visible) seg_d = dec_seg;
        dp_d = (cur_st != ST_DP);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_q        <= '0;
      k_q        <= '0;
      primed_q   <= 1'b0;
      snap_dig_q <= '0;
      snap_st_q  <= '0;
      ac_q       <= '1;
      seg_q      <= SEG_BLANK;
      dp_q       <= 1'b1;
      fd_q       <= 1'b0;
    end else begin
      s_q        <= s_d;
      k_q        <= k_d;
      primed_q   <= primed_d;
      snap_dig_q <= snap_dig_d;
      snap_st_q  <= snap_st_d;
      ac_q       <= ac_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
      fd_q       <= fd_d;
    end
  end

  assign AC         = ac_q;
  assign SEG        = seg_q;
  assign DP         = dp_q;
  assign FRAME_DONE = fd_q;

endmodule

// File: tb/tb_modulo_varredura_display_ac.sv
// Self-checking bench for modulo_varredura_display_ac (N_DIG=4, DIV=8, BLANK=2, BLINK_FRAMES=2).
// Expected outputs come from a model based on a count of enabled cycles.
module tb_modulo_varredura_display_ac;

  localparam int N  = 4;
  localparam int DV = 8;
  localparam int BL = 2;
  localparam int BF = 2;
  localparam int FL = N * DV;
  localparam logic [12:0] IDLE_V = 13'h1FFE;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] digits;
  logic [7:0]  stat;
  logic [3:0]  ac;
  logic [6:0]  seg;
  logic        dp;
  logic        fd;

  always #5 clk = ~clk;

  modulo_varredura_display_ac #(
    .N_DIG(N), .DIV(DV), .BLANK(BL), .BLINK_FRAMES(BF)
  ) dut (
    .CLK(clk), .RST_N(rst_n), .EN(en), .DIGITS(digits), .STAT(stat),
    .AC(ac), .SEG(seg), .DP(dp), .FRAME_DONE(fd)
  );

  int errors = 0;
  int checks = 0;

  int unsigned m_t;
  int unsigned m_frames;
  bit          m_primed;
  logic [15:0] m_sd;
  logic [7:0]  m_ss;
  logic [12:0] exp_v;
  wire  [12:0] got_v = {ac, seg, dp, fd};

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
      4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
      4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
      4'd9: return 7'h10;  default: return 7'b0111111;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_frames = 0; m_primed = 0; m_sd = '0; m_ss = '0;
  endtask

  // Predict the registered outputs for the coming edge, clock once, advance the model.
  task automatic step();
    int s, k, code;
    bit vis, last;
    logic [15:0] dg;
    logic [7:0]  st;
    logic [3:0]  a;
    logic [6:0]  sg;
    logic        p, f;
    s = int'(m_t % DV);
    k = int'((m_t / DV) % N);
    last = (s == DV - 1) && (k == N - 1);
    dg = m_primed ? m_sd : digits;
    st = m_primed ? m_ss : stat;
    a = 4'hF; sg = 7'h7F; p = 1'b1; f = 1'b0;
    if (en) begin
      f = last;
      if (s >= BL) begin
        a = ~(4'b0001 << k);
        code = int'(st[2*k +: 2]);
        vis = (code != 0);
`ifdef SCAN_BLINK_EN
        if (code == 2 && ((m_frames / BF) % 2) == 1) vis = 0;
`endif
        sg = vis ? ref_seg(dg[4*k +: 4]) : 7'h7F;
        p = (code == 3) ? 1'b0 : 1'b1;
      end
    end
    exp_v = {a, sg, p, f};
    @(posedge clk);
    if (en) begin
      if (!m_primed || last) begin m_sd = digits; m_ss = stat; end
      if (last) m_frames++;
      m_primed = 1;
      m_t++;
    end
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (got_v !== IDLE_V) begin errors++; $display("FAIL reset_values got=%h exp=%h", got_v, IDLE_V); end
    en = 0;
    repeat (3) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL reset_idle got=%h exp=%h", got_v, exp_v); end
    end
  endtask

  task automatic test_scan();
    int fds = 0, col0 = 0;
    digits = 16'h4321; stat = 8'h55; en = 1;
    for (int i = 1; i <= 64; i++) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL scan t=%0d got=%h exp=%h", m_t, got_v, exp_v); end
      if (fd) fds++;
      if (i <= 32 && ac == 4'b1110) col0++;
      if (i == 3 || i == 11 || i == 19 || i == 27) begin
        logic [10:0] want;
        case (i)
          3:  want = {4'b1110, 7'h79};
          11: want = {4'b1101, 7'h24};
          19: want = {4'b1011, 7'h30};
          default: want = {4'b0111, 7'h19};
        endcase
        checks++;
        if ({ac, seg} !== want) begin errors++; $display("FAIL scan_column step=%0d got=%h exp=%h", i, {ac, seg}, want); end
      end
    end
    checks++;
    if (fds != 2) begin errors++; $display("FAIL frame_done_count got=%0d exp=2", fds); end
    checks++;
    if (col0 != 6) begin errors++; $display("FAIL column_duty got=%0d exp=6", col0); end
  endtask

  task automatic test_snapshot();
    int unsigned pre;
    repeat (10) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL snap_pre got=%h exp=%h", got_v, exp_v); end
    end
    digits = 16'h9999;
    repeat (30) begin
      pre = m_t;
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL snap t=%0d got=%h exp=%h", m_t, got_v, exp_v); end
      if (pre == 74 || pre == 90 || pre == 98) begin
        logic [6:0] want;
        want = (pre == 74) ? 7'h24 : (pre == 90) ? 7'h19 : 7'h10;
        checks++;
        if (seg !== want) begin errors++; $display("FAIL snap_hold t=%0d got=%h exp=%h", pre, seg, want); end
      end
    end
  endtask

  task automatic test_status();
    int guard = 0;
    digits = 16'h432B; stat = 8'h17;
    while (m_t % FL != 0 && guard < 64) begin
      step(); guard++;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL status_align got=%h exp=%h", got_v, exp_v); end
    end
    repeat (3) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL status got=%h exp=%h", got_v, exp_v); end
    end
    checks++;
    if ({ac, seg, dp} !== {4'b1110, 7'b0111111, 1'b0}) begin
      errors++; $display("FAIL status_dash_dp got=%h exp=%h", {ac, seg, dp}, {4'b1110, 7'b0111111, 1'b0});
    end
    repeat (24) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL status got=%h exp=%h", got_v, exp_v); end
    end
    checks++;
    if ({ac, seg, dp} !== {4'b0111, 7'h7F, 1'b1}) begin
      errors++; $display("FAIL status_off got=%h exp=%h", {ac, seg, dp}, {4'b0111, 7'h7F, 1'b1});
    end
  endtask

  task automatic test_blink();
    int blanks = 0;
    digits = 16'h4321; stat = 8'h65;
    repeat (5 * FL) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL blink t=%0d got=%h exp=%h", m_t, got_v, exp_v); end
      if (ac == 4'b1011 && seg == 7'h7F) blanks++;
    end
    checks++;
`ifdef SCAN_BLINK_EN
    if (blanks < 12) begin errors++; $display("FAIL blink_blank_cycles got=%0d exp>=12", blanks); end
`else
    if (blanks != 0) begin errors++; $display("FAIL blink_blank_cycles got=%0d exp=0", blanks); end
`endif
  endtask

  task automatic test_enable_pause();
    int guard = 0;
    stat = 8'h55;
    while (m_t % FL != 21 && guard < 64) begin
      step(); guard++;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL pause_align got=%h exp=%h", got_v, exp_v); end
    end
    en = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (got_v !== exp_v || got_v !== IDLE_V) begin errors++; $display("FAIL pause_idle got=%h exp=%h", got_v, IDLE_V); end
    end
    en = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL pause_resume got=%h exp=%h", got_v, exp_v); end
      checks++;
      if (ac !== ((i < 3) ? 4'b1011 : 4'b1111)) begin
        errors++; $display("FAIL pause_column i=%0d got=%b exp=%b", i, ac, (i < 3) ? 4'b1011 : 4'b1111);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) == 0) digits = 16'($urandom);
      if ($urandom_range(0, 9) == 0) stat = 8'($urandom);
      en = ($urandom_range(0, 4) != 0);
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL random t=%0d got=%h exp=%h", m_t, got_v, exp_v); end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    en = 1;
    while (!(m_t % FL >= 26 && m_t % FL <= 30) && guard < 64) begin
      step(); guard++;
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL areset_align got=%h exp=%h", got_v, exp_v); end
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if (got_v !== IDLE_V) begin errors++; $display("FAIL areset_immediate got=%h exp=%h", got_v, IDLE_V); end
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (got_v !== IDLE_V) begin errors++; $display("FAIL areset_hold got=%h exp=%h", got_v, IDLE_V); end
    @(negedge clk);
    rst_n = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      checks++;
      if (got_v !== exp_v) begin errors++; $display("FAIL areset_restart got=%h exp=%h", got_v, exp_v); end
      if (i == 3) begin
        checks++;
        if (ac !== 4'b1110) begin errors++; $display("FAIL areset_column0 got=%b exp=1110", ac); end
      end
    end
  endtask

  initial begin
    rst_n = 0; en = 0; digits = '0; stat = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    test_reset();
    test_scan();
    test_snapshot();
    test_status();
    test_blink();
    test_enable_pause();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
